rc4_keystream_xor_stage: RTL and testbench
==========================================

// Module: rc4_keystream_xor_stage
// PURPOSE
//  Downstream consumer of the RC4 pseudo-random generator. Sequences the generator
//  (state-array init, then one keystream byte per request), XORs each keystream byte
//  with one ciphertext byte from the input stream, and emits plaintext on a
//  valid/ready stream. Processes one message of programmable length per start pulse.
// PARAMETERS
//  LEN_W       16    width of message length / byte counter
//  KS_TIMEOUT  1023  max cycles to wait for sarrGenerated_i or valReady_i before error
// PORTS
//  clk              in   1      single clock, all logic rising-edge
//  rst              in   1      synchronous, active-high reset
//  start_i          in   1      1-cycle pulse: begin message (ignored unless IDLE)
//  msg_len_i        in   LEN_W  bytes in message, sampled on start_i; 0 = done at once
//  gen_state_arr_o  out  1      to generator genStateArr_i: request S-array build
//  gen_val_o        out  1      to generator genVal_i: request next keystream byte
//  sarr_generated_i in   1      from generator: S-array build complete
//  val_ready_i      in   1      from generator: keystream byte valid this cycle
//  keystream_i      in   8      from generator outputToXor_o
//  cipher_valid_i   in   1      ciphertext byte valid
//  cipher_data_i    in   8      ciphertext byte
//  cipher_ready_o   out  1      ciphertext accepted when valid & ready
//  plain_valid_o    out  1      plaintext byte valid
//  plain_data_o     out  8      plaintext byte
//  plain_ready_i    in   1      downstream accepts when valid & ready
//  busy_o           out  1      high in every state except IDLE
//  done_o           out  1      1-cycle pulse: last byte accepted downstream
//  err_o            out  1      sticky timeout flag, cleared by rst or next start_i
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; counters and data registers 0.
//  FSM states/transitions:
//   IDLE    : start_i & msg_len_i!=0 -> INIT (latch len, cnt=0, clear err_o);
//             start_i & len==0 -> done_o pulse next cycle, stay IDLE.
//   INIT    : gen_state_arr_o=1 held; sarr_generated_i -> REQ.
//   REQ     : gen_val_o=1 for exactly one cycle -> WAIT.
//   WAIT    : val_ready_i -> latch keystream_i into ks_q -> CIN.
//   CIN     : cipher_ready_o=1; on cipher_valid_i: plain_q = cipher_data_i ^ ks_q -> OUT.
//   OUT     : plain_valid_o=1, plain_data_o=plain_q stable until plain_ready_i;
//             on accept: cnt+1; cnt+1==len -> IDLE with done_o pulse, else -> REQ.
//   ERR     : entered from INIT/WAIT when timeout counter reaches KS_TIMEOUT;
//             err_o=1, all handshakes low; leaves only on start_i (-> INIT) or rst.
//  Timeout counter: clears on each state entry; counts only in INIT and WAIT.
//  Outputs are registered (Moore); val_ready_i in same cycle as REQ entry is ignored.
//  Latency: val_ready_i to cipher_ready_o 1 cycle; cipher accept to plain_valid_o 1 cycle.
//  Exactly one keystream byte consumed per plaintext byte; never prefetched.
//  Byte counter is LEN_W bits, no wrap: max message 2^LEN_W-1 bytes.
//  start_i while busy_o=1 ignored. rst mid-message: abort, no done_o, to IDLE.
// CONFIGURATION
//  RC4_XOR_CHECKSUM_EN defined: adds output csum_o[7:0]; cleared on start_i,
//   csum_o <= csum_o + plain_data_o (mod 256) on each downstream accept; valid
//   and stable from done_o until next start_i.
//  Not defined: no csum_o port, no checksum logic.
// TESTING
//  rst held 2 cycles -> all outputs 0, busy_o=0.
//  len=3, ks 0x5A,0x00,0xFF, cipher 0x12,0x34,0x56 -> plain 0x48,0x34,0xA9, done_o once.
//  plain_ready_i low 5 cycles in OUT -> plain_data_o stable, no extra gen_val_o.
//  sarr_generated_i never arrives -> err_o=1 after KS_TIMEOUT+1 cycles; start_i recovers.
//  start_i with len=0 -> done_o next cycle, no gen_state_arr_o or gen_val_o.
//  CHECKSUM_EN, plain 0x80,0x90 -> csum_o=0x10 at done_o.

Source files
------------

// File: rtl/rc4_keystream_xor_stage.sv
// rc4_keystream_xor_stage
//   Drives an RC4 keystream generator and decrypts one message per start pulse.
//   The generator is asked to build its S-array once, then one keystream byte
//   is requested per ciphertext byte. Each keystream byte is XORed with one
//   ciphertext byte and the result goes out on the plaintext stream.
//
// Optional feature (macro RC4_XOR_CHECKSUM_EN):
//   Adds csum_o, the mod-256 sum of all plaintext bytes accepted downstream.
//   It is cleared on an accepted start_i and holds its value after done_o.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   start_i           : 1-cycle pulse, begins a message (IDLE/ERR only)
//   msg_len_i         : message length in bytes, sampled with start_i
//   gen_state_arr_o   : to generator, request S-array build (held in INIT)
//   gen_val_o         : to generator, request one keystream byte (1 cycle)
//   sarr_generated_i  : from generator, S-array build complete
//   val_ready_i       : from generator, keystream_i valid this cycle
//   keystream_i       : from generator, keystream byte
//   cipher_*          : ciphertext input stream
//   plain_*           : plaintext output stream
//   busy_o            : high in every state except IDLE
//   done_o            : 1-cycle pulse after the last byte is accepted
//   err_o             : generator timeout; cleared by rst or the next start_i
//   csum_o            : plaintext checksum (RC4_XOR_CHECKSUM_EN only)
//   dbg_state_o       : current FSM state encoding
//
// Handshake rule for both streams: a byte transfers on a rising edge where
// valid and ready are both high; the producer holds valid and data stable
// until that edge.
module rc4_keystream_xor_stage #(
    parameter int LEN_W      = 16,
    parameter int KS_TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [LEN_W-1:0] msg_len_i,
    output logic             gen_state_arr_o,
    output logic             gen_val_o,
    input  logic             sarr_generated_i,
    input  logic             val_ready_i,
    input  logic [7:0]       keystream_i,
    input  logic             cipher_valid_i,
    input  logic [7:0]       cipher_data_i,
    output logic             cipher_ready_o,
    output logic             plain_valid_o,
    output logic [7:0]       plain_data_o,
    input  logic             plain_ready_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
`ifdef RC4_XOR_CHECKSUM_EN
    output logic [7:0]       csum_o,
`endif
    output logic [2:0]       dbg_state_o
);

    localparam int TO_W = $clog2(KS_TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_INIT = 3'd1,
        ST_REQ  = 3'd2,
        ST_WAIT = 3'd3,
        ST_CIN  = 3'd4,
        ST_OUT  = 3'd5,
        ST_ERR  = 3'd6
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] cnt_inc;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [7:0]       ks_q;
    logic [7:0]       plain_q;
    logic             done_q, done_d;
    logic             start_acc;
    logic             ks_load;
    logic             pt_load;
    logic             out_acc;
    logic             timed_out;

    assign cnt_inc   = cnt_q + LEN_W'(1);
    assign timed_out = (to_cnt_q == TO_W'(KS_TIMEOUT));

    always_comb begin
        state_d   = state_q;
        done_d    = 1'b0;
        start_acc = 1'b0;
        ks_load   = 1'b0;
        pt_load   = 1'b0;
        out_acc   = 1'b0;
        case (state_q)
            ST_IDLE, ST_ERR: begin
                if (start_i) begin
                    start_acc = 1'b1;
                    if (msg_len_i != '0) begin
                        state_d = ST_INIT;
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_INIT: begin
                if (sarr_generated_i)  state_d = ST_REQ;
                else if (timed_out)    state_d = ST_ERR;
            end
            // One-cycle request; a val_ready_i seen here is not for us yet.
            ST_REQ: state_d = ST_WAIT;
            ST_WAIT: begin
                if (val_ready_i) begin
                    ks_load = 1'b1;
                    state_d = ST_CIN;
                end else if (timed_out) begin
                    state_d = ST_ERR;
                end
            end
            ST_CIN: begin
                if (cipher_valid_i) begin
                    pt_load = 1'b1;
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                if (plain_ready_i) begin
                    out_acc = 1'b1;
                    if (cnt_inc == len_q) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Timeout counter restarts on every state change and only runs while
    // waiting on the generator.
    always_comb begin
        to_cnt_d = to_cnt_q;
        if (state_d != state_q)
            to_cnt_d = '0;
        else if (state_q == ST_INIT || state_q == ST_WAIT)
            to_cnt_d = to_cnt_q + TO_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            len_q    <= '0;
            cnt_q    <= '0;
            to_cnt_q <= '0;
            ks_q     <= '0;
            plain_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            to_cnt_q <= to_cnt_d;
            done_q   <= done_d;
            if (start_acc) begin
                len_q <= msg_len_i;
                cnt_q <= '0;
            end else if (out_acc) begin
                cnt_q <= cnt_inc;
            end
            if (ks_load) ks_q    <= keystream_i;
            if (pt_load) plain_q <= cipher_data_i ^ ks_q;
        end
    end

`ifdef RC4_XOR_CHECKSUM_EN
    logic [7:0] csum_q;

    always_ff @(posedge clk) begin
        if (rst)            csum_q <= '0;
        else if (start_acc) csum_q <= '0;
        else if (out_acc)   csum_q <= csum_q + plain_q;
    end

    assign csum_o = csum_q;
`endif

    // Moore outputs decoded straight from the state register.
    assign gen_state_arr_o = (state_q == ST_INIT);
    assign gen_val_o       = (state_q == ST_REQ);
    assign cipher_ready_o  = (state_q == ST_CIN);
    assign plain_valid_o   = (state_q == ST_OUT);
    assign plain_data_o    = plain_q;
    assign busy_o          = (state_q != ST_IDLE);
    assign done_o          = done_q;
    assign err_o           = (state_q == ST_ERR);
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_rc4_keystream_xor_stage.sv
// Bench for rc4_keystream_xor_stage: the bench plays the keystream generator
// and both stream endpoints. Expected plaintext is pushed to exp_q when a
// keystream/ciphertext pair is driven and popped when plain_data_o is taken.
module tb_rc4_keystream_xor_stage;

    localparam int LEN_W      = 16;
    localparam int KS_TIMEOUT = 1023;

    logic             clk = 1'b0;
    logic             rst;
    logic             start_i;
    logic [LEN_W-1:0] msg_len_i;
    logic             gen_state_arr_o;
    logic             gen_val_o;
    logic             sarr_generated_i;
    logic             val_ready_i;
    logic [7:0]       keystream_i;
    logic             cipher_valid_i;
    logic [7:0]       cipher_data_i;
    logic             cipher_ready_o;
    logic             plain_valid_o;
    logic [7:0]       plain_data_o;
    logic             plain_ready_i;
    logic             busy_o;
    logic             done_o;
    logic             err_o;
    logic [2:0]       dbg_state_o;
`ifdef RC4_XOR_CHECKSUM_EN
    logic [7:0]       csum_o;
`endif

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    rc4_keystream_xor_stage #(.LEN_W(LEN_W), .KS_TIMEOUT(KS_TIMEOUT)) dut (
        .clk              (clk),
        .rst              (rst),
        .start_i          (start_i),
        .msg_len_i        (msg_len_i),
        .gen_state_arr_o  (gen_state_arr_o),
        .gen_val_o        (gen_val_o),
        .sarr_generated_i (sarr_generated_i),
        .val_ready_i      (val_ready_i),
        .keystream_i      (keystream_i),
        .cipher_valid_i   (cipher_valid_i),
        .cipher_data_i    (cipher_data_i),
        .cipher_ready_o   (cipher_ready_o),
        .plain_valid_o    (plain_valid_o),
        .plain_data_o     (plain_data_o),
        .plain_ready_i    (plain_ready_i),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .err_o            (err_o),
`ifdef RC4_XOR_CHECKSUM_EN
        .csum_o           (csum_o),
`endif
        .dbg_state_o      (dbg_state_o)
    );

    // ---------------- scoreboard state ----------------
    logic [7:0] exp_q[$];
    logic [7:0] ks_tab[0:7];
    logic [7:0] ct_tab[0:7];
    int n_checks = 0;
    int n_fail   = 0;

    // Pulse counters; sampled on the rising edge so the main sequence,
    // which works on falling edges, never races them.
    int n_gen_val  = 0;
    int n_gen_sarr = 0;
    int n_done     = 0;
    always @(posedge clk) begin
        if (gen_val_o)       n_gen_val++;
        if (gen_state_arr_o) n_gen_sarr++;
        if (done_o)          n_done++;
    end

    // ---------------- checkers ----------------
    task automatic chk_b(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_start(input int len);
        start_i   = 1'b1;
        msg_len_i = LEN_W'(len);
        tick();
        start_i   = 1'b0;
    endtask

    task automatic wait_gen_val();
        int w = 0;
        while (!gen_val_o && w < 50) begin
            tick();
            w++;
        end
        chk_b("gen_val_request", gen_val_o, 1'b1);
    endtask

    // Full message: start, S-array handshake, then per byte a keystream
    // reply, a ciphertext byte and a downstream accept after 'hold' stalls.
    task automatic run_msg(input int len, input int hold);
        int gv0;
        int dn0;
        logic [7:0] exp_b;
        gv0 = n_gen_val;
        dn0 = n_done;
        do_start(len);
        chk_b("busy_after_start", busy_o, 1'b1);
        chk_b("err_clear_on_start", err_o, 1'b0);
        chk_b("gen_state_arr_in_init", gen_state_arr_o, 1'b1);
        sarr_generated_i = 1'b1;
        tick();
        sarr_generated_i = 1'b0;
        for (int i = 0; i < len; i++) begin
            wait_gen_val();
            exp_q.push_back(ct_tab[i] ^ ks_tab[i]);
            tick();
            chk_b("gen_val_one_cycle", gen_val_o, 1'b0);
            val_ready_i = 1'b1;
            keystream_i = ks_tab[i];
            tick();
            val_ready_i = 1'b0;
            keystream_i = 8'h00;
            chk_b("cipher_ready", cipher_ready_o, 1'b1);
            cipher_valid_i = 1'b1;
            cipher_data_i  = ct_tab[i];
            tick();
            cipher_valid_i = 1'b0;
            cipher_data_i  = 8'h00;
            chk_b("plain_valid", plain_valid_o, 1'b1);
            exp_b = exp_q[0];
            for (int h = 0; h < hold; h++) begin
                tick();
                chk_b("plain_valid_held", plain_valid_o, 1'b1);
                chk_w("plain_data_stable", 32'(plain_data_o), 32'(exp_b));
            end
            plain_ready_i = 1'b1;
            exp_b = exp_q.pop_front();
            chk_w("plain_data", 32'(plain_data_o), 32'(exp_b));
            tick();
            plain_ready_i = 1'b0;
            chk_b("done_timing", done_o, (i == len - 1));
        end
        tick();
        chk_b("done_one_cycle", done_o, 1'b0);
        chk_b("idle_after_msg", busy_o, 1'b0);
        chk_w("gen_val_count", n_gen_val - gv0, len);
        chk_w("done_count", n_done - dn0, 1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int waited;
        int gv0;
        int gs0;
        int dn0;
        rst              = 1'b1;
        start_i          = 1'b0;
        msg_len_i        = '0;
        sarr_generated_i = 1'b0;
        val_ready_i      = 1'b0;
        keystream_i      = 8'h00;
        cipher_valid_i   = 1'b0;
        cipher_data_i    = 8'h00;
        plain_ready_i    = 1'b0;

        // Reset held two cycles.
        repeat (2) tick();
        chk_b("rst_busy", busy_o, 1'b0);
        chk_b("rst_gen_state_arr", gen_state_arr_o, 1'b0);
        chk_b("rst_gen_val", gen_val_o, 1'b0);
        chk_b("rst_cipher_ready", cipher_ready_o, 1'b0);
        chk_b("rst_plain_valid", plain_valid_o, 1'b0);
        chk_w("rst_plain_data", 32'(plain_data_o), 32'h0);
        chk_b("rst_done", done_o, 1'b0);
        chk_b("rst_err", err_o, 1'b0);
        chk_w("rst_state", 32'(dbg_state_o), 32'h0);
        rst = 1'b0;
        tick();

        // Known-answer message.
        ks_tab[0] = 8'h5A; ks_tab[1] = 8'h00; ks_tab[2] = 8'hFF;
        ct_tab[0] = 8'h12; ct_tab[1] = 8'h34; ct_tab[2] = 8'h56;
        chk_w("kat_model_0", 32'(ct_tab[0] ^ ks_tab[0]), 32'h48);
        chk_w("kat_model_2", 32'(ct_tab[2] ^ ks_tab[2]), 32'hA9);
        run_msg(3, 0);

        // Downstream stall: data held, no extra keystream request.
        for (int i = 0; i < 2; i++) begin
            ks_tab[i] = 8'($urandom_range(0, 255));
            ct_tab[i] = 8'($urandom_range(0, 255));
        end
        run_msg(2, 5);

        // Random message.
        for (int i = 0; i < 5; i++) begin
            ks_tab[i] = 8'($urandom_range(0, 255));
            ct_tab[i] = 8'($urandom_range(0, 255));
        end
        run_msg(5, $urandom_range(0, 2));

        // Zero-length message.
        gv0 = n_gen_val;
        gs0 = n_gen_sarr;
        dn0 = n_done;
        do_start(0);
        chk_b("len0_done", done_o, 1'b1);
        chk_b("len0_busy", busy_o, 1'b0);
        tick();
        chk_b("len0_done_pulse", done_o, 1'b0);
        tick();
        chk_w("len0_no_gen_val", n_gen_val - gv0, 0);
        chk_w("len0_no_gen_state_arr", n_gen_sarr - gs0, 0);
        chk_w("len0_done_count", n_done - dn0, 1);

        // Generator never finishes the S-array.
        do_start(2);
        waited = 0;
        while (!err_o && waited < 2 * KS_TIMEOUT) begin
            tick();
            waited++;
        end
        chk_w("timeout_cycles", waited, KS_TIMEOUT + 1);
        chk_b("timeout_err", err_o, 1'b1);
        chk_b("timeout_busy", busy_o, 1'b1);
        chk_b("timeout_no_gen_state_arr", gen_state_arr_o, 1'b0);
        repeat (3) tick();
        chk_b("err_sticky", err_o, 1'b1);
        chk_b("err_no_done", done_o, 1'b0);
        ks_tab[0] = 8'hC3;
        ct_tab[0] = 8'h3C;
        run_msg(1, 1);

        // Reset in the middle of a message.
        dn0 = n_done;
        do_start(2);
        sarr_generated_i = 1'b1;
        tick();
        sarr_generated_i = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_b("abort_busy", busy_o, 1'b0);
        chk_b("abort_gen_val", gen_val_o, 1'b0);
        tick();
        chk_w("abort_no_done", n_done - dn0, 0);

`ifdef RC4_XOR_CHECKSUM_EN
        ks_tab[0] = 8'h00; ks_tab[1] = 8'h00;
        ct_tab[0] = 8'h80; ct_tab[1] = 8'h90;
        run_msg(2, 0);
        chk_w("csum", 32'(csum_o), 32'h10);
`endif

        chk_w("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
